tap_tempo: RTL

- Inverse of the metronome path: a player taps a push-button and the block measures the time between taps.
- It converts the averaged tap interval into a tempo in BPM.
- Output `speed[7:0]` has the same encoding as the band/metronome `speed` bus, so it can be muxed onto that bus in place of the up/down button value.

---
 rtl/metronome_pkg.sv | 25 ++
 rtl/tempo_div.sv | 74 +++++++
 rtl/tap_tempo.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/metronome_pkg.sv
// Shared tempo constants and FSM encoding for the metronome / tap-tempo blocks.
// Values below correspond to the default TICK_HZ=1000, MIN_BPM=30, MAX_BPM=250.
package metronome_pkg;

   localparam int TIMEOUT_TICKS = 2000;
   localparam int MIN_IVL_TICKS = 240;
   localparam int BPM_NUMERATOR = 60000;
   localparam logic [7:0] DEFAULT_SPEED = 8'd60;

   localparam int IVL_W = 11;
   localparam int SUM_W = 13;
   localparam int DIV_W = 18;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_DIVIDE  = 2'd2
   } tt_state_e;

   // Ticks per beat at a given tempo.
   function automatic int bpm_to_ticks(input int tick_hz, input int bpm);
      return (60 * tick_hz) / bpm;
   endfunction

endpackage

// File: rtl/tempo_div.sv
// Unsigned sequential restoring divider: one load cycle, then one quotient bit per clock.
// done pulses for one cycle once quot holds the truncated result.
module tempo_div #(
   parameter int DATA_W = 18
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              abort,
   input  logic              start,
   input  logic [DATA_W-1:0] num,
   input  logic [DATA_W-1:0] den,
   output logic              done,
   output logic [DATA_W-1:0] quot
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   logic              r_run;
   logic              r_done;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_rem;
   logic [DATA_W-1:0] r_q;
   logic [DATA_W-1:0] r_den;
   logic [DATA_W:0]   w_shift;
   logic [DATA_W:0]   w_diff;
   logic              w_ge;

   assign w_shift = {r_rem, r_q[DATA_W-1]};
   assign w_diff  = w_shift - {1'b0, r_den};
   assign w_ge    = (w_shift >= {1'b0, r_den});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_run  <= 1'b0;
         r_done <= 1'b0;
         r_cnt  <= '0;
      end else begin
         r_done <= 1'b0;
         if (abort) begin
            r_run <= 1'b0;
         end else if (start) begin
            r_run <= 1'b1;
            r_cnt <= CNT_W'(DATA_W);
         end else if (r_run) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
               r_run  <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   // Datapath: r_q starts as the numerator and is shifted into the quotient bit by bit.
   always_ff @(posedge clk) begin
      if (start) begin
         r_rem <= '0;
         r_q   <= num;
         r_den <= den;
      end else if (r_run) begin
         if (w_ge) begin
            r_rem <= w_diff[DATA_W-1:0];
            r_q   <= {r_q[DATA_W-2:0], 1'b1};
         end else begin
            r_rem <= w_shift[DATA_W-1:0];
            r_q   <= {r_q[DATA_W-2:0], 1'b0};
         end
      end
   end

   assign done = r_done;
   assign quot = r_q;

endmodule

// File: rtl/tap_tempo.sv
// Tap-tempo: debounces a push-button, averages up to AVG_N tap intervals and
// converts the mean interval into BPM on the same encoding as the metronome speed bus.
module tap_tempo
   import metronome_pkg::*;
#(
   parameter int CLK_HZ         = 25000000,
   parameter int TICK_HZ        = 1000,
   parameter int DEBOUNCE_TICKS = 10,
   parameter int MIN_BPM        = 30,
   parameter int MAX_BPM        = 250,
   parameter int AVG_N          = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tap,
   input  logic       clear,
   output logic [7:0] speed,
   output logic       speed_valid,
   output logic       busy,
   output logic       tracking
);

   localparam int TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DB_W     = $clog2(DEBOUNCE_TICKS + 1);
   localparam int N_W      = $clog2(AVG_N + 1);
   localparam int TIMEOUT  = bpm_to_ticks(TICK_HZ, MIN_BPM);
   localparam int MIN_IVL  = bpm_to_ticks(TICK_HZ, MAX_BPM);
   localparam int NUMER    = 60 * TICK_HZ;

   function automatic logic [7:0] clamp_bpm(input logic [DIV_W-1:0] q);
      if (q < DIV_W'(MIN_BPM))      return 8'(MIN_BPM);
      else if (q > DIV_W'(MAX_BPM)) return 8'(MAX_BPM);
      else                          return q[7:0];
   endfunction

   logic             r_tap_s1, r_tap_s2;
   logic [PRE_W-1:0] r_pre;
   logic             w_tick;
   logic             r_db_lvl, r_db_lvl_d;
   logic [DB_W-1:0]  r_db_cnt;
   logic             w_tap_ev;

   tt_state_e        r_state, w_state_nxt;
   logic [IVL_W-1:0] r_ivl;
   logic             w_timeout, w_ivl_ok, w_accept, w_restart, w_hist_clr;

   logic [IVL_W-1:0] r_hist [AVG_N];
   logic [N_W-1:0]   r_n, w_n_nxt;
   logic [SUM_W-1:0] r_sum, w_sum_nxt;
   logic [IVL_W-1:0] w_evict;

   logic [DIV_W-1:0] w_num, w_den, w_quot;
   logic             w_div_done;
   logic [7:0]       r_speed;
   logic             r_speed_vld;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tap_s1 <= 1'b0;
         r_tap_s2 <= 1'b0;
         r_pre    <= '0;
      end else begin
         r_tap_s1 <= tap;
         r_tap_s2 <= r_tap_s1;
         r_pre    <= w_tick ? '0 : r_pre + 1'b1;
      end
   end

   assign w_tick = (r_pre == PRE_W'(TICK_DIV - 1));

   // Any cycle where the synced level matches the stable level restarts the debounce window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_db_lvl   <= 1'b0;
         r_db_lvl_d <= 1'b0;
         r_db_cnt   <= '0;
      end else begin
         r_db_lvl_d <= r_db_lvl;
         if (r_tap_s2 == r_db_lvl) begin
            r_db_cnt <= '0;
         end else if (w_tick) begin
            if (r_db_cnt == DB_W'(DEBOUNCE_TICKS - 1)) begin
               r_db_lvl <= r_tap_s2;
               r_db_cnt <= '0;
            end else begin
               r_db_cnt <= r_db_cnt + 1'b1;
            end
         end
      end
   end

   assign w_tap_ev  = r_db_lvl & ~r_db_lvl_d;
   assign w_timeout = (r_ivl == IVL_W'(TIMEOUT));
   assign w_ivl_ok  = (r_ivl >= IVL_W'(MIN_IVL)) && (r_ivl < IVL_W'(TIMEOUT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (w_tap_ev) w_state_nxt = ST_MEASURE;
         ST_MEASURE: begin
            if (w_timeout)                 w_state_nxt = ST_IDLE;
            else if (w_tap_ev && w_ivl_ok) w_state_nxt = ST_DIVIDE;
         end
         ST_DIVIDE:  if (w_div_done) w_state_nxt = ST_MEASURE;
         default:    w_state_nxt = ST_IDLE;
      endcase
      if (clear) w_state_nxt = ST_IDLE;
   end

   always_comb begin
      busy     = 1'b0;
      tracking = 1'b0;
      case (r_state)
         ST_MEASURE: tracking = 1'b1;
         ST_DIVIDE: begin
            busy     = 1'b1;
            tracking = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_accept   = (r_state == ST_MEASURE) && (w_state_nxt == ST_DIVIDE);
   assign w_restart  = (r_state == ST_IDLE) && (w_state_nxt == ST_MEASURE);
   assign w_hist_clr = clear || ((r_state == ST_MEASURE) && w_timeout);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                  r_ivl <= '0;
      else if (clear || w_accept || w_restart)  r_ivl <= '0;
      else if (w_tick && !w_timeout)            r_ivl <= r_ivl + 1'b1;
   end

   // Running sum drops the oldest entry only once the history is full.
   assign w_evict   = (r_n == N_W'(AVG_N)) ? r_hist[AVG_N-1] : '0;
   assign w_sum_nxt = r_sum + SUM_W'(r_ivl) - SUM_W'(w_evict);
   assign w_n_nxt   = (r_n == N_W'(AVG_N)) ? r_n : r_n + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_n   <= '0;
         r_sum <= '0;
      end else if (w_hist_clr) begin
         r_n   <= '0;
         r_sum <= '0;
      end else if (w_accept) begin
         r_n   <= w_n_nxt;
         r_sum <= w_sum_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_hist[0] <= r_ivl;
         for (int i = 1; i < AVG_N; i++) r_hist[i] <= r_hist[i-1];
      end
   end

   // The divider loads in the accept cycle from the post-push n and sum.
   assign w_num = DIV_W'(NUMER) * DIV_W'(w_n_nxt);
   assign w_den = DIV_W'(w_sum_nxt);

   tempo_div #(
      .DATA_W (DIV_W)
   ) u_div (
      .clk   (clk),
      .rst   (rst),
      .abort (clear),
      .start (w_accept),
      .num   (w_num),
      .den   (w_den),
      .done  (w_div_done),
      .quot  (w_quot)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_speed     <= DEFAULT_SPEED;
         r_speed_vld <= 1'b0;
      end else begin
         r_speed_vld <= 1'b0;
         if ((r_state == ST_DIVIDE) && w_div_done && !clear) begin
            r_speed     <= clamp_bpm(w_quot);
            r_speed_vld <= 1'b1;
         end
      end
   end

   assign speed       = r_speed;
   assign speed_valid = r_speed_vld;

endmodule
